// File: rtl/sdram_pro_read.sv
// rtl/sdram_pro_read.sv - full-page-burst SDRAM read engine
`timescale 1ns/1ps
module sdram_pro_read #(
    parameter int CAS_LATENCY = 3,
    parameter int CNT_TRCD    = 2,
    parameter int CNT_TRP     = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [22:0] rd_addr,
    input  logic [9:0]  rd_burst_len,
    input  logic [15:0] sdram_data_in,
    output logic [3:0]  rd_sdram_cmd,
    output logic [11:0] rd_sdram_addr,
    output logic [1:0]  rd_sdram_bank,
    output logic        rd_ack,
    output logic [15:0] rd_sdram_data,
    output logic        rd_end
);

    localparam logic [3:0] CMD_NOP    = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_READ   = 4'b0101;
    localparam logic [3:0] CMD_BST    = 4'b0110;
    localparam logic [3:0] CMD_PRE    = 4'b0010;

    typedef enum logic [2:0] {
        RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_DATA, RD_PRECHARGE, RD_TRP, RD_END
    } state_t;

    state_t      state;
    logic [22:0] lat_addr;
    logic [9:0]  lat_len;
    logic [9:0]  cnt;
    logic [9:0]  cnt_nxt;
    logic [9:0]  pre_pt;
    logic        ack_nxt;

    // From READ onward cnt counts bus cycles since READ; cnt_nxt is the cycle being scheduled.
    always_comb begin
        cnt_nxt = cnt + 10'd1;
        pre_pt  = lat_len + 10'(CAS_LATENCY);
        ack_nxt = (cnt_nxt > 10'(CAS_LATENCY)) && (cnt_nxt <= pre_pt);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= RD_IDLE;
            lat_addr      <= '0;
            lat_len       <= '0;
            cnt           <= '0;
            rd_sdram_cmd  <= CMD_NOP;
            rd_sdram_addr <= 12'hfff;
            rd_sdram_bank <= 2'b11;
            rd_ack        <= 1'b0;
            rd_sdram_data <= '0;
            rd_end        <= 1'b0;
        end else begin
            rd_sdram_cmd  <= CMD_NOP;
            rd_sdram_addr <= 12'hfff;
            rd_sdram_bank <= 2'b11;
            rd_ack        <= 1'b0;
            rd_end        <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (init_end && rd_en && rd_burst_len != 10'd0) begin
                        state    <= RD_ACTIVE;
                        lat_addr <= rd_addr;
                        lat_len  <= rd_burst_len;
                        cnt      <= '0;
                    end
                end
                RD_ACTIVE: begin
                    rd_sdram_cmd  <= CMD_ACTIVE;
                    rd_sdram_bank <= lat_addr[22:21];
                    rd_sdram_addr <= lat_addr[20:9];
                    cnt           <= '0;
                    state         <= RD_TRCD;
                end
                RD_TRCD: begin
                    if (cnt == 10'(CNT_TRCD)) begin
                        rd_sdram_cmd  <= CMD_READ;
                        rd_sdram_bank <= lat_addr[22:21];
                        rd_sdram_addr <= {3'b000, lat_addr[8:0]};
                        cnt           <= '0;
                        state         <= RD_READ;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                RD_READ, RD_DATA: begin
                    cnt    <= cnt_nxt;
                    rd_ack <= ack_nxt;
                    if (ack_nxt) begin
                        rd_sdram_data <= sdram_data_in;
                    end
                    // For a 512-word burst the terminate coincides with the page wrap.
                    if (cnt_nxt == lat_len) begin
                        rd_sdram_cmd <= CMD_BST;
                    end
                    if (cnt_nxt == pre_pt) begin
                        rd_sdram_cmd <= CMD_PRE;
                        cnt          <= '0;
                        state        <= RD_PRECHARGE;
                    end else begin
                        state <= RD_DATA;
                    end
                end
                RD_PRECHARGE: begin
                    if (CNT_TRP == 0) begin
                        rd_end <= 1'b1;
                        state  <= RD_END;
                    end else begin
                        cnt   <= 10'd1;
                        state <= RD_TRP;
                    end
                end
                RD_TRP: begin
                    if (cnt == 10'(CNT_TRP)) begin
                        rd_end <= 1'b1;
                        state  <= RD_END;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                RD_END: begin
                    cnt   <= '0;
                    state <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdram_pro_read.md
Name: sdram_pro_read

Overview:
- Full-page-burst read engine for the SDRAM controller; mirror of the write engine under the same arbiter.
- Opens a row, issues READ, waits CAS latency, captures rd_burst_len words (1..512) from the SDRAM data bus, truncates the page burst with BURST_TERMINATE, then precharges.
- Outputs a registered command/address/bank set plus a data-valid strobe that feeds the downstream read FIFO write side.

Parameters:
- CAS_LATENCY, 3, SDRAM CL in clocks (2 or 3); must match the mode register set by the init block.
- CNT_TRCD, 2, NOP cycles between ACTIVE and READ.
- CNT_TRP, 2, NOP cycles after PRECHARGE before rd_end.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- init_end  input  1  SDRAM initialisation complete; no command is issued before it is high.
- rd_en  input  1  read request from the arbiter.
- rd_addr  input  23  bank[22:21], row[20:9], column[8:0].
- rd_burst_len  input  10  words to read, 1..512.
- sdram_data_in  input  16  SDRAM DQ bus (read direction).
- rd_sdram_cmd  output  4  command using the shared `defines encodings (NO_OPERATION, ACTIVE, READ, BURST_TERMINATE, PRECHARGE).
- rd_sdram_addr  output  12  SDRAM address bus.
- rd_sdram_bank  output  2  SDRAM bank select.
- rd_ack  output  1  high exactly while rd_sdram_data holds a valid burst word.
- rd_sdram_data  output  16  registered copy of sdram_data_in.
- rd_end  output  1  one-cycle pulse: transaction finished, bank precharged.

Behaviour:
- Reset values: cmd NO_OPERATION, addr 12'hfff, bank 2'b11, rd_ack 0, rd_sdram_data 0, rd_end 0, state RD_IDLE, all counters 0.
- States: RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_DATA, RD_PRECHARGE, RD_TRP, RD_END.
- RD_IDLE:
  - Leaves to RD_ACTIVE when init_end && rd_en && rd_burst_len != 0.
  - rd_burst_len == 0 is ignored; the block stays in RD_IDLE.
  - rd_addr and rd_burst_len are latched on that transition; later input changes have no effect on the current transaction.
- Command bus (all outputs registered):
  - Bus cycle 0 = ACTIVE, bank = addr[22:21], addr = row.
  - ACTIVE reaches the pins 2 clocks after rd_en is sampled.
  - Cycles 1..CNT_TRCD: NOP.
  - Cycle R = CNT_TRCD+1: READ, bank latched, addr = {3'b000, column}.
- Burst truncation:
  - BURST_TERMINATE at cycle R+L, where L = latched length.
  - If L == 512, BST lands on the page wrap: no extra word is produced; the 512th word is the last captured.
- Data capture:
  - Word k is on sdram_data_in at cycle R+CAS_LATENCY+k and is registered into rd_sdram_data one cycle later.
  - rd_ack is high for exactly L consecutive cycles, R+CAS_LATENCY+1 through R+CAS_LATENCY+L.
  - rd_sdram_data holds its last value when rd_ack is low.
- Precharge and end:
  - PRECHARGE at cycle R+CAS_LATENCY+L with addr 12'hfff (A10 high, all banks) and bank 2'b11.
  - Then CNT_TRP NOP cycles, then rd_end high for exactly one cycle, then RD_IDLE.
  - Every cycle not listed above drives NOP, addr 12'hfff, bank 2'b11.
- Burst counter: 10 bits, so 512 is representable. Comparisons are against the latched length; there is no wrap-around of the counter.
- rd_en dropping mid-transaction is ignored; the transaction always completes.
- rd_en still high when RD_IDLE is re-entered starts a new transaction immediately.
- init_end falling mid-transaction is ignored.
- Asynchronous reset mid-transaction returns all outputs to reset values immediately; no BST or PRECHARGE is emitted, and the init block re-initialises the device.

Test Plan:
- Reset asserted mid-RD_DATA -> same edge: cmd NOP, addr 12'hfff, bank 2'b11, rd_ack 0; no further commands until a new rd_en after init_end.
- init_end=1, rd_addr=23'h5A_A123 (bank 2, row 12'hD50, col 9'h123), len=4, CL=3 -> ACTIVE bank2/row D50, 2 NOPs, READ col 123, BST at R+4, PRECHARGE at R+7; rd_ack high cycles R+4..R+7 carrying model words 0..3; rd_end at R+10.
- len=1 -> READ then BST next cycle; exactly one rd_ack cycle; rd_end pulse once.
- len=512, col 0 -> 512 rd_ack cycles, data matches columns 0..511 with no repeated column 0; PRECHARGE immediately after.
- rd_en held high with init_end=0 -> bus stays NOP; assert init_end -> ACTIVE 2 clocks later. rd_burst_len=0 with rd_en=1 -> no command issued.
- rd_en held high through rd_end, len=2 -> second ACTIVE follows RD_IDLE re-entry; address change mid-burst does not affect the current transaction.
